// File: rtl/alu_sequencer.sv
// Control path for the 8-bit ALU: fetches one- or two-byte instructions, keeps a
// 4x8 register file, sequences ALU operations, jumps, branches and data-memory loads/stores.
module alu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       run_i,
  output logic [7:0] imem_addr_o,
  output logic       imem_req_o,
  input  logic [7:0] imem_data_i,
  input  logic       imem_ack_i,
  output logic [7:0] alu_instruction_o,
  output logic [7:0] alu_in0_o,
  output logic [7:0] alu_in1_o,
  input  logic [7:0] alu_out_i,
  input  logic [7:0] alu_jump_i,
  input  logic       alu_overflow_i,
  output logic [7:0] dmem_addr_o,
  output logic [7:0] dmem_wdata_o,
  output logic       dmem_re_o,
  output logic       dmem_we_o,
  input  logic [7:0] dmem_rdata_i,
  input  logic       dmem_ack_i,
  output logic [7:0] pc_o,
  output logic       ovf_flag_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_FETCH2 = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      imm_q, imm_d;
  logic [7:0]      instr_q, instr_d;
  logic [7:0]      in0_q, in0_d;
  logic [7:0]      in1_q, in1_d;
  logic [7:0]      ldata_q, ldata_d;
  logic            ovf_q, ovf_d;
  logic [3:0][7:0] rf_q, rf_d;

  logic [3:0] op_s;
  logic [1:0] rs_s;
  logic [1:0] rt_s;

  function automatic logic two_byte(input logic [3:0] op);
    logic r;
    case (op)
      4'b1000, 4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111: r = 1'b1;
      default:                                              r = 1'b0;
    endcase
    return r;
  endfunction

  assign op_s = ir_q[7:4];
  assign rs_s = ir_q[3:2];
  assign rt_s = ir_q[1:0];

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
      instr_q <= 8'h00;
      in0_q   <= 8'h00;
      in1_q   <= 8'h00;
      ldata_q <= 8'h00;
      ovf_q   <= 1'b0;
      rf_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      instr_q <= instr_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      ldata_q <= ldata_d;
      ovf_q   <= ovf_d;
      rf_q    <= rf_d;
    end
  end

  // Next-state, operand staging and write-back
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    instr_d = instr_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    ldata_d = ldata_q;
    ovf_d   = ovf_q;
    rf_d    = rf_q;
    case (state_q)
      S_FETCH: begin
        if (run_i && imem_ack_i) begin
          ir_d    = imem_data_i;
          state_d = two_byte(imem_data_i[7:4]) ? S_FETCH2 : S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH2: begin
        if (imem_ack_i) begin
          imm_d   = imem_data_i;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH2;
        end
      end
      S_DECODE: begin
        // Immediate forms feed imm on in0; branches compare rs against rt.
        if (op_s == 4'b1110 || op_s == 4'b1111) begin
          in0_d = imm_q;
          in1_d = rf_q[rs_s];
        end else if (op_s == 4'b1100 || op_s == 4'b1101) begin
          in0_d = rf_q[rs_s];
          in1_d = rf_q[rt_s];
        end else begin
          in0_d = rf_q[rt_s];
          in1_d = rf_q[rs_s];
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        instr_d = ir_q;
        state_d = (op_s == 4'b1010 || op_s == 4'b1011) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ack_i) begin
          ldata_d = dmem_rdata_i;
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        case (op_s)
          4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
            rf_d[rs_s] = alu_out_i;
            pc_d       = pc_q + 8'd1;
          end
          4'b0001: begin
            rf_d[rs_s] = alu_out_i;
            ovf_d      = ovf_q | alu_overflow_i;
            pc_d       = pc_q + 8'd1;
          end
          4'b1000: pc_d = imm_q;
          4'b1001: begin
            rf_d[3] = pc_q + 8'd2;
            pc_d    = imm_q;
          end
          4'b1010: begin
            rf_d[rs_s] = ldata_q;
            pc_d       = pc_q + 8'd1;
          end
          4'b1011: pc_d = pc_q + 8'd1;
          4'b1100, 4'b1101: pc_d = (alu_jump_i == 8'hFF) ? imm_q : pc_q + 8'd2;
          4'b1110, 4'b1111: begin
            rf_d[rs_s] = alu_out_i;
            pc_d       = pc_q + 8'd2;
          end
          default: pc_d = pc_q + 8'd1;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Fetch request is masked while reset is held so nothing is requested before release.
  assign imem_req_o        = ~reset_i & (((state_q == S_FETCH) & run_i) | (state_q == S_FETCH2));
  assign imem_addr_o       = (state_q == S_FETCH2) ? pc_q + 8'd1 : pc_q;
  assign dmem_re_o         = (state_q == S_MEM) & (op_s == 4'b1010);
  assign dmem_we_o         = (state_q == S_MEM) & (op_s == 4'b1011);
  assign dmem_addr_o       = rf_q[rt_s];
  assign dmem_wdata_o      = rf_q[rs_s];
  assign alu_instruction_o = instr_q;
  assign alu_in0_o         = in0_q;
  assign alu_in1_o         = in1_q;
  assign pc_o              = pc_q;
  assign ovf_flag_o        = ovf_q;
  assign busy_o            = ~((state_q == S_FETCH) & ~run_i);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU and memories, and an
// instruction-level reference model that predicts PC, registers, flag, operands and latency.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset, run;
  logic [7:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic       imem_req, imem_ack, dmem_re, dmem_we, dmem_ack;
  logic [7:0] alu_instruction, alu_in0, alu_in1, alu_out, alu_jump, pc;
  logic       alu_overflow, ovf_flag, busy;

  logic [7:0] imem [256];
  logic [7:0] dmem [256];
  int         dmem_delay = 0;
  int         wait_cnt = 0;
  int         we_cycles = 0;
  int         n_writes = 0;
  logic [7:0] last_waddr = 8'h00, last_wdata = 8'h00;

  logic [7:0] m_r [4];
  logic [7:0] m_pc;
  logic       m_ovf;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.RESET_PC(8'h00)) dut (
    .clk_i(clk), .reset_i(reset), .run_i(run),
    .imem_addr_o(imem_addr), .imem_req_o(imem_req), .imem_data_i(imem_data), .imem_ack_i(imem_ack),
    .alu_instruction_o(alu_instruction), .alu_in0_o(alu_in0), .alu_in1_o(alu_in1),
    .alu_out_i(alu_out), .alu_jump_i(alu_jump), .alu_overflow_i(alu_overflow),
    .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_re_o(dmem_re), .dmem_we_o(dmem_we),
    .dmem_rdata_i(dmem_rdata), .dmem_ack_i(dmem_ack),
    .pc_o(pc), .ovf_flag_o(ovf_flag), .busy_o(busy)
  );

  // Behavioural ALU: returns {overflow, jump, out}. Non-ALU opcodes raise overflow to prove it is ignored.
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] o, j;
    logic       v;
    o = 8'h00; j = a ^ b; v = 1'b0;
    case (op)
      4'd0:  o = a;
      4'd1:  begin o = a + b; v = (a[7] == b[7]) && (o[7] != a[7]); end
      4'd2:  o = a & b;
      4'd3:  o = a | b;
      4'd4:  o = a ^ b;
      4'd5:  o = b - a;
      4'd6:  o = ~a;
      4'd7:  o = b >> 1;
      4'd12: j = (a == b) ? 8'hFF : 8'h00;
      4'd13: j = (a != b) ? 8'hFF : 8'h00;
      4'd14: begin o = a + b; v = (a[7] == b[7]) && (o[7] != a[7]); end
      4'd15: o = a;
      default: begin o = 8'h5A; v = 1'b1; end
    endcase
    return {v, j, o};
  endfunction

  assign {alu_overflow, alu_jump, alu_out} = alu_fn(alu_instruction[7:4], alu_in0, alu_in1);
  assign imem_ack   = imem_req;
  assign imem_data  = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  assign dmem_ack   = (dmem_re | dmem_we) && (wait_cnt == dmem_delay);

  always @(posedge clk) begin
    if ((dmem_re | dmem_we) && !dmem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (dmem_we) we_cycles <= we_cycles + 1;
    if (dmem_we && dmem_ack) begin
      last_waddr <= dmem_addr;
      last_wdata <= dmem_wdata;
      n_writes   <= n_writes + 1;
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    m_pc = 8'h00; m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
  endtask

  // Executes one instruction in the model and checks the DUT cycle-exactly against it.
  task automatic step(input int delay);
    logic [7:0]  ir, imm, p1, in0, in1, npc, a, d;
    logic [3:0]  op;
    logic [1:0]  rs, rt;
    logic [16:0] res;
    logic        two;
    int          cyc, w0, nw0;
    p1 = m_pc + 8'd1;
    ir = imem[m_pc]; imm = imem[p1];
    op = ir[7:4]; rs = ir[3:2]; rt = ir[1:0];
    two = (op == 4'd8) || (op == 4'd9) || (op >= 4'd12);
    in0 = (op >= 4'd14) ? imm : ((op == 4'd12 || op == 4'd13) ? m_r[rs] : m_r[rt]);
    in1 = (op == 4'd12 || op == 4'd13) ? m_r[rt] : m_r[rs];
    res = alu_fn(op, in0, in1);
    a = m_r[rt]; d = m_r[rs];
    dmem_delay = delay; w0 = we_cycles; nw0 = n_writes;
    cyc = two ? 5 : ((op == 4'd10 || op == 4'd11) ? 5 + delay : 4);
    repeat (cyc - 1) @(posedge clk);
    #1;
    checks++; if (pc !== m_pc) begin errors++; $display("FAIL early_pc ir=%h got=%h exp=%h", ir, pc, m_pc); end
    checks++; if (alu_instruction !== ir) begin errors++; $display("FAIL alu_instr got=%h exp=%h", alu_instruction, ir); end
    checks++; if (alu_in0 !== in0) begin errors++; $display("FAIL alu_in0 ir=%h got=%h exp=%h", ir, alu_in0, in0); end
    checks++; if (alu_in1 !== in1) begin errors++; $display("FAIL alu_in1 ir=%h got=%h exp=%h", ir, alu_in1, in1); end
    npc = m_pc + 8'd1;
    case (op)
      4'd8:  npc = imm;
      4'd9:  begin m_r[3] = m_pc + 8'd2; npc = imm; end
      4'd10: m_r[rs] = dmem[a];
      4'd11: ;
      4'd12, 4'd13: npc = (res[15:8] == 8'hFF) ? imm : m_pc + 8'd2;
      4'd14, 4'd15: begin m_r[rs] = res[7:0]; npc = m_pc + 8'd2; end
      default: begin
        m_r[rs] = res[7:0];
        if (op == 4'd1 && res[16]) m_ovf = 1'b1;
      end
    endcase
    @(posedge clk); #1;
    checks++; if (pc !== npc) begin errors++; $display("FAIL pc ir=%h got=%h exp=%h", ir, pc, npc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.rf_q[i] !== m_r[i]) begin errors++; $display("FAIL reg%0d ir=%h got=%h exp=%h", i, ir, dut.rf_q[i], m_r[i]); end
    end
    checks++; if (ovf_flag !== m_ovf) begin errors++; $display("FAIL ovf ir=%h got=%b exp=%b", ir, ovf_flag, m_ovf); end
    if (op == 4'd11) begin
      checks++; if (n_writes !== nw0 + 1) begin errors++; $display("FAIL store_count got=%0d exp=%0d", n_writes, nw0 + 1); end
      checks++; if (last_waddr !== a) begin errors++; $display("FAIL store_addr got=%h exp=%h", last_waddr, a); end
      checks++; if (last_wdata !== d) begin errors++; $display("FAIL store_data got=%h exp=%h", last_wdata, d); end
      checks++; if (we_cycles - w0 !== delay + 1) begin errors++; $display("FAIL we_cycles got=%0d exp=%0d", we_cycles - w0, delay + 1); end
      dmem[a] = d;
    end
    m_pc = npc;
  endtask

  task automatic test_reset();
    clear_imem();
    run = 1'b1;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req_held got=%b exp=0", imem_req); end
    reset = 1'b0; #1;
    m_pc = 8'h00; m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", imem_addr); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
    checks++; if (alu_instruction !== 8'h00) begin errors++; $display("FAIL reset_instr got=%h exp=00", alu_instruction); end
    checks++; if ({ovf_flag, dmem_re, dmem_we} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {ovf_flag, dmem_re, dmem_we}); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dut.rf_q[i] !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got=%h exp=00", i, dut.rf_q[i]); end
    end
  endtask

  task automatic test_li_add();
    clear_imem();
    imem[0] = 8'hF0; imem[1] = 8'h05; imem[2] = 8'hF4; imem[3] = 8'h03; imem[4] = 8'h11;
    do_reset();
    repeat (3) step(0);
    checks++; if (pc !== 8'h05) begin errors++; $display("FAIL li_add_pc got=%h exp=05", pc); end
    checks++; if (dut.rf_q[0] !== 8'h08) begin errors++; $display("FAIL li_add_r0 got=%h exp=08", dut.rf_q[0]); end
    checks++; if (dut.rf_q[1] !== 8'h03) begin errors++; $display("FAIL li_add_r1 got=%h exp=03", dut.rf_q[1]); end
  endtask

  task automatic test_overflow();
    clear_imem();
    imem[0] = 8'hF0; imem[1] = 8'h70; imem[2] = 8'hF4; imem[3] = 8'h70; imem[4] = 8'h11; imem[5] = 8'h21;
    do_reset();
    repeat (3) step(0);
    checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_flag); end
    step(0);
    checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_flag); end
    do_reset();
    checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf_flag); end
  endtask

  task automatic test_branch();
    clear_imem();
    imem[0] = 8'hF0; imem[1] = 8'h03; imem[2] = 8'hF4; imem[3] = 8'h03; imem[4] = 8'hC1; imem[5] = 8'h20;
    do_reset();
    repeat (3) step(0);
    checks++; if (pc !== 8'h20) begin errors++; $display("FAIL branch_taken got=%h exp=20", pc); end
    imem[1] = 8'h05;
    do_reset();
    repeat (3) step(0);
    checks++; if (pc !== 8'h06) begin errors++; $display("FAIL branch_not_taken got=%h exp=06", pc); end
  endtask

  task automatic test_jal();
    clear_imem();
    imem[0] = 8'h80; imem[1] = 8'h10; imem[8'h10] = 8'h90; imem[8'h11] = 8'h40;
    do_reset();
    repeat (2) step(0);
    checks++; if (dut.rf_q[3] !== 8'h12) begin errors++; $display("FAIL jal_link got=%h exp=12", dut.rf_q[3]); end
    checks++; if (pc !== 8'h40) begin errors++; $display("FAIL jal_pc got=%h exp=40", pc); end
  endtask

  task automatic test_mem();
    clear_imem();
    imem[0] = 8'hF0; imem[1] = 8'h30; imem[2] = 8'hF4; imem[3] = 8'h77; imem[4] = 8'hB4; imem[5] = 8'hA8;
    dmem[8'h30] = 8'h11;
    do_reset();
    repeat (2) step(0);
    step(3);
    checks++; if (last_waddr !== 8'h30 || last_wdata !== 8'h77) begin errors++; $display("FAIL store_0x30 got=%h/%h exp=30/77", last_waddr, last_wdata); end
    step(2);
    checks++; if (dut.rf_q[2] !== 8'h77) begin errors++; $display("FAIL load_r2 got=%h exp=77", dut.rf_q[2]); end
  endtask

  task automatic test_reset_mid_mem();
    int nw0;
    clear_imem();
    imem[0] = 8'hF0; imem[1] = 8'h30; imem[2] = 8'hF4; imem[3] = 8'h77; imem[4] = 8'hB4;
    do_reset();
    repeat (2) step(0);
    dmem_delay = 20; nw0 = n_writes;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL mem_we_pending got=%b exp=1", dmem_we); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({dmem_we, dmem_re, imem_req} !== 3'b000) begin errors++; $display("FAIL reset_mem_drop got=%b exp=000", {dmem_we, dmem_re, imem_req}); end
    checks++; if (n_writes !== nw0) begin errors++; $display("FAIL reset_mem_write got=%0d exp=%0d", n_writes, nw0); end
    do_reset();
    checks++; if (dut.rf_q[1] !== 8'h00) begin errors++; $display("FAIL reset_mem_reg got=%h exp=00", dut.rf_q[1]); end
  endtask

  task automatic test_run_stall();
    clear_imem();
    imem[0] = 8'h11;
    do_reset();
    @(posedge clk); #1;
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL stall_complete got=%h exp=01", pc); end
    checks++; if ({busy, imem_req} !== 2'b00) begin errors++; $display("FAIL stall_idle got=%b exp=00", {busy, imem_req}); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL stall_hold got=%h exp=01", pc); end
    run = 1'b1; #1;
    checks++; if ({busy, imem_req} !== 2'b11) begin errors++; $display("FAIL stall_resume got=%b exp=11", {busy, imem_req}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 8'($urandom);
      dmem[i] = 8'($urandom);
    end
    do_reset();
    for (int k = 0; k < 80; k++) step(int'($urandom_range(0, 3)));
  endtask

  initial begin
    reset = 1'b1; run = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    test_reset();
    test_li_add();
    test_overflow();
    test_branch();
    test_jal();
    test_mem();
    test_reset_mid_mem();
    test_run_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control sequencer that drives the 8-bit ALU's instruction/operand ports and consumes its `out`, `jump` and `overflow` results. It fetches 8-bit instructions from instruction memory and holds a 4×8 register file. It executes the ALU's 16-opcode set and performs loads and stores over a data-memory handshake. It sits between instruction/data memory and the ALU as the CPU's control path.

## Interface
Parameters:
- `RESET_PC`, 8'h00, PC value loaded on reset.

Ports:
- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high reset. Decided: one clock; reset is synchronous and active-high.
- `run` input 1: sequencer leaves FETCH only while high.
- `imem_addr` output 8: instruction fetch address.
- `imem_req` output 1: fetch request; held until ack.
- `imem_data` input 8: instruction byte, valid when `imem_ack`=1.
- `imem_ack` input 1: fetch complete; may assert in the first `imem_req` cycle.
- `alu_instruction` output 8: to ALU `instruction`.
- `alu_in0` output 8: to ALU `in0`.
- `alu_in1` output 8: to ALU `in1`.
- `alu_out` input 8: from ALU `out`.
- `alu_jump` input 8: from ALU `jump`; 8'hFF means branch taken.
- `alu_overflow` input 1: from ALU `overflow`.
- `dmem_addr`, `dmem_wdata` output 8: data-memory address and write data.
- `dmem_re`, `dmem_we` output 1: read/write strobes; held until ack.
- `dmem_rdata` input 8: read data, valid with `dmem_ack`.
- `dmem_ack` input 1: data access complete.
- `pc` output 8: current PC.
- `ovf_flag` output 1: sticky signed-add overflow.
- `busy` output 1: high in every state except idle FETCH with `run`=0.

## Operation
- **Instruction byte:** opcode [7:4], rs [3:2], rt [1:0].
- **Two-byte opcodes:** 1000, 1001, 1100, 1101, 1110, 1111. The second byte is `imm`, fetched from PC+1.
- **Operand mapping:** `alu_in0`=R[rt] and `alu_in1`=R[rs], except:
  - addi (1110) and li (1111): `alu_in0`=imm.
  - Branches: `alu_in0`=R[rs], `alu_in1`=R[rt].
- **Writeback to R[rs]:** opcodes 0000–0111, 1110, 1111, and load data for 1010.
- **Jumps:**
  - 1000 sets PC←imm.
  - 1001 sets R[3]←PC+2, then PC←imm.
- **Memory:**
  - 1010 load: R[rs]←mem[R[rt]].
  - 1011 store: mem[R[rt]]←R[rs].
- **Branches (1100/1101):** PC←imm if `alu_jump`==8'hFF, else PC+2.
- **PC advance:** all other opcodes set PC←PC+1 (one-byte) or PC+2 (two-byte). All PC arithmetic is mod 256.
- **Overflow:** `ovf_flag` is set only when opcode==0001 and `alu_overflow`=1 at WB. It clears only on reset. `alu_overflow` is ignored for every other opcode.
- **`alu_jump`:** sampled only for 1100/1101.

State machine:
- **FETCH:** if `run`, assert `imem_req` with `imem_addr`=PC. On ack, latch IR and go to FETCH2 (two-byte opcode) or DECODE.
- **FETCH2:** request PC+1; on ack, latch imm and go to DECODE.
- **DECODE:** drive `alu_in0`/`alu_in1` from the register file and imm. `alu_instruction` is unchanged.
- **EXEC:** `alu_instruction`←IR, with operands already stable. Go to MEM for 1010/1011, else WB.
- **MEM:** assert `dmem_re` or `dmem_we` with `dmem_addr`=R[rt] (and `dmem_wdata`=R[rs] for stores) until `dmem_ack`. Load data is latched on ack.
- **WB:** sample ALU outputs, write the register, update PC, return to FETCH.

## Timing
- **Reset:** registers, IR, imm and all outputs are 0 (`alu_instruction`=8'h00, Move), `pc`=`RESET_PC`, state=FETCH.
- **Reset mid-operation:** reset in any state (including MEM or a pending fetch) drops `imem_req`/`dmem_re`/`dmem_we` on the next edge. No register-file write occurs that cycle.
- **Zero-wait latency:**
  - One-byte ALU op: 4 cycles.
  - Two-byte op: 5 cycles.
  - Load/store: 5 cycles plus memory wait cycles.
- **Operand/opcode order:** operands change only in DECODE; `alu_instruction` changes only in EXEC. ALU results are sampled in WB, one cycle after EXEC.
- **`run` dropped mid-instruction:** the current instruction completes; the sequencer stalls at the next FETCH.
- **Simultaneous events:**
  - R[3] as JAL link and as destination: the link write wins.
  - Register writes take effect the cycle after WB.

## Test plan
- **Reset:** reset with `run`=1, release → `imem_req`=1, `imem_addr`=0x00, `pc`=0x00, all regs 0.
- **li/add:** program F0 05, F4 03, 11 → R0=0x08, R1=0x03, `pc`=0x05, `ovf_flag`=0; the ADD takes 4 cycles with zero-wait memory.
- **Overflow:** ADD with the bench ALU model returning `alu_overflow`=1 sets `ovf_flag`=1. A following AND (0x21) keeps it at 1; reset clears it.
- **Branch taken vs. not:**
  - R0=R1=0x03, C1 20 → `pc`=0x20.
  - R0=0x05, R1=0x03, C1 20 → `pc`=PC+2.
- **JAL:** 90 40 at 0x10 → R3=0x12, `pc`=0x40.
- **Load/store with waits:**
  - B4 with R0=0x30, R1=0x77, 3-cycle `dmem_ack` delay → `dmem_we` high 4 cycles, address 0x30, data 0x77.
  - A8 → R2=`dmem_rdata`.
  - Reset during MEM → `dmem_we`=0 next cycle.
